// File: rtl/uart_rx_if.sv
// Serial receive link: line input plus received-byte outputs and status strobes.
// master drives the line and observes results; slave is the receiver.
interface uart_rx_if;
  logic       rxd;
  logic [7:0] rxdata;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    output rxd,
    input  rxdata,
    input  rx_valid,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  rxd,
    output rxdata,
    output rx_valid,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first. Synchronizes rxd, checks the start bit at half a bit,
// samples data mid-bit and strobes rx_valid or frame_err after the stop sample.
module uart_rx #(
  parameter int unsigned BIT_CLK = 87
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);

  localparam int unsigned HALF    = (BIT_CLK - 1) / 2;
  localparam logic [7:0]  HalfM1  = 8'(HALF - 1);
  localparam logic [7:0]  LastCnt = 8'(BIT_CLK - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e     state_q, state_d;
  logic       s1_q, s2_q;
  logic [7:0] count_q, count_d;
  logic [2:0] index_q, index_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rxdata_q, rxdata_d;
  logic       rx_valid_q, rx_valid_d;
  logic       frame_err_q, frame_err_d;
  logic       busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    index_d     = index_q;
    shift_d     = shift_q;
    rxdata_d    = rxdata_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      StIdle: begin
        count_d = 8'd0;
        index_d = 3'd0;
        if (!s2_q) state_d = StStart;
      end
      // The entry edge counts as the first start-bit cycle, so the check lands at E+HALF.
      StStart: begin
        count_d = count_q + 8'd1;
        if (count_q == HalfM1) begin
          count_d = 8'd0;
          state_d = s2_q ? StIdle : StData;
        end
      end
      StData: begin
        count_d = count_q + 8'd1;
        if (count_q == LastCnt) begin
          count_d          = 8'd0;
          shift_d[index_q] = s2_q;
          index_d          = index_q + 3'd1;
          if (index_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        count_d = count_q + 8'd1;
        if (count_q == LastCnt) begin
          count_d = 8'd0;
          if (s2_q) begin
            rxdata_d   = shift_q;
            rx_valid_d = 1'b1;
            state_d    = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end
      end
      StBreak: begin
        count_d = 8'd0;
        if (s2_q) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        count_d = 8'd0;
        index_d = 3'd0;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q        <= 1'b1;
      s2_q        <= 1'b1;
      state_q     <= StIdle;
      count_q     <= 8'd0;
      index_q     <= 3'd0;
      shift_q     <= 8'd0;
      rxdata_q    <= 8'd0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      s1_q        <= bus.rxd;
      s2_q        <= s1_q;
      state_q     <= state_d;
      count_q     <= count_d;
      index_q     <= index_d;
      shift_q     <= shift_d;
      rxdata_q    <= rxdata_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.rxdata    = rxdata_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;

endmodule
